// File: rtl/tdm_demux_8ch.sv
// Receive-side 8-channel TDM demultiplexer: routes a serial sample stream round-robin
// into eight channel registers and holds each complete frame until acknowledged.
module tdm_demux_8ch #(
  parameter int WIDTH = 3,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sync,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic [SEL_W-1:0] ch,
  output logic             misalign
);

  localparam int NCH = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST = '1;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_ch;
  logic [WIDTH-1:0] r_y [NCH];
  logic             r_in_ready;
  logic             r_frame_valid;
  logic             r_misalign;

  logic             w_accept;
  logic [SEL_W-1:0] w_widx;

  assign w_accept = in_valid & r_in_ready;
  // A sync coinciding with an accept forces the sample into channel 0.
  assign w_widx   = sync ? '0 : r_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= COLLECT;
      r_ch          <= '0;
      r_in_ready    <= 1'b0;
      r_frame_valid <= 1'b0;
      r_misalign    <= 1'b0;
      for (int i = 0; i < NCH; i++) r_y[i] <= '0;
    end else begin
      r_misalign <= (r_state == COLLECT) && sync && (r_ch != '0);
      case (r_state)
        COLLECT: begin
          r_in_ready    <= 1'b1;
          r_frame_valid <= 1'b0;
          if (w_accept) begin
            r_y[w_widx] <= in_data;
            if (w_widx == LAST) begin
              r_ch          <= '0;
              r_state       <= HOLD;
              r_in_ready    <= 1'b0;
              r_frame_valid <= 1'b1;
            end else begin
              r_ch <= w_widx + 1'b1;
            end
          end else if (sync) begin
            r_ch <= '0;
          end
        end
        HOLD: begin
          if (frame_ack) begin
            r_state       <= COLLECT;
            r_in_ready    <= 1'b1;
            r_frame_valid <= 1'b0;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign frame_valid = r_frame_valid;
  assign misalign    = r_misalign;
  assign ch          = r_ch;
  assign y0 = r_y[0];
  assign y1 = r_y[1];
  assign y2 = r_y[2];
  assign y3 = r_y[3];
  assign y4 = r_y[4];
  assign y5 = r_y[5];
  assign y6 = r_y[6];
  assign y7 = r_y[7];

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Bench for tdm_demux_8ch: directed frame scenarios followed by random traffic,
// all compared against a frame-level reference model.
module tb_tdm_demux_8ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       sync;
  logic       frame_valid;
  logic       frame_ack;
  logic [2:0] y_obs [8];
  logic [2:0] ch;
  logic       misalign;

  int total = 0;
  int bad   = 0;

  // reference model state
  int  m_y [8];
  int  m_pos;
  bit  m_full;
  bit  m_ready;
  bit  m_mis;

  always #5 clk = ~clk;

  tdm_demux_8ch #(.WIDTH(3), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sync(sync), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .y0(y_obs[0]), .y1(y_obs[1]), .y2(y_obs[2]), .y3(y_obs[3]),
    .y4(y_obs[4]), .y5(y_obs[5]), .y6(y_obs[6]), .y7(y_obs[7]),
    .ch(ch), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_y%0d", tag, i), {29'd0, y_obs[i]}, m_y[i]);
    chk({tag, "_ch"},  {29'd0, ch}, m_pos);
    chk({tag, "_fv"},  {31'd0, frame_valid}, {31'd0, m_full});
    chk({tag, "_rdy"}, {31'd0, in_ready}, {31'd0, m_ready});
    chk({tag, "_mis"}, {31'd0, misalign}, {31'd0, m_mis});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_y[i] = 0;
    m_pos = 0; m_full = 0; m_ready = 0; m_mis = 0;
  endtask

  // One clock edge of the frame-level behaviour.
  task automatic model_edge(input bit v, input int d, input bit s, input bit a);
    int slot;
    m_mis = 0;
    if (m_full) begin
      if (a) m_full = 0;
    end else begin
      m_mis = s && (m_pos != 0);
      if (v && m_ready) begin
        slot = s ? 0 : m_pos;
        m_y[slot] = d;
        m_pos = (slot + 1) % 8;
        m_full = (slot == 7);
      end else if (s) begin
        m_pos = 0;
      end
    end
    m_ready = !m_full;
  endtask

  task automatic cycle(input bit v, input int d, input bit s, input bit a, input string tag);
    in_valid = v; in_data = 3'(d); sync = s; frame_ack = a;
    @(posedge clk);
    model_edge(v, d, s, a);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all({tag, "_imm"});
    @(posedge clk);
    #1 check_all({tag, "_held"});
    #2 rst_n = 1'b1;
    cycle(0, 0, 0, 0, {tag, "_rel"});
    chk({tag, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 0; sync = 0; frame_ack = 0;
    model_reset();
    #2 check_all("reset");
    #10 rst_n = 1'b1;
    cycle(0, 0, 0, 0, "first_rdy");

    // frame 0..7
    for (int i = 0; i < 8; i++) cycle(1, i, 0, 0, "f1");
    for (int i = 0; i < 8; i++) chk($sformatf("f1_const_y%0d", i), {29'd0, y_obs[i]}, i);
    chk("f1_fv_const", {31'd0, frame_valid}, 32'd1);

    // hold with valid data that must be ignored, then ack
    for (int i = 0; i < 5; i++) cycle(1, 7, 0, 0, "hold");
    cycle(0, 0, 0, 1, "ack1");
    for (int i = 0; i < 8; i++) cycle(1, 7 - i, 0, 0, "f2");
    chk("f2_y0_const", {29'd0, y_obs[0]}, 32'd7);
    chk("f2_y7_const", {29'd0, y_obs[7]}, 32'd0);
    cycle(1, 5, 0, 1, "ack2");

    // sync with accept mid-frame
    cycle(1, 5, 0, 0, "s1"); cycle(1, 6, 0, 0, "s1"); cycle(1, 7, 0, 0, "s1");
    cycle(1, 2, 1, 0, "sync_acc");
    chk("sync_acc_y0", {29'd0, y_obs[0]}, 32'd2);
    chk("sync_acc_ch", {29'd0, ch}, 32'd1);
    chk("sync_acc_mis", {31'd0, misalign}, 32'd1);
    for (int i = 0; i < 7; i++) cycle(1, i, 0, 0, "s1_rest");
    chk("s1_fv", {31'd0, frame_valid}, 32'd1);
    cycle(0, 0, 1, 1, "ack3_sync_hold");

    // sync without accept at ch=4
    for (int i = 0; i < 4; i++) cycle(1, 3, 0, 0, "s2");
    cycle(0, 0, 1, 0, "sync_idle");
    chk("sync_idle_ch", {29'd0, ch}, 32'd0);
    for (int i = 0; i < 8; i++) cycle(1, 6 - (i % 3), 0, 0, "s2_rest");
    cycle(0, 0, 0, 1, "ack4");

    // alternating valid
    for (int i = 0; i < 16; i++) cycle(!(i % 2), i / 2, 0, 0, "alt");
    for (int i = 0; i < 8; i++) chk($sformatf("alt_const_y%0d", i), {29'd0, y_obs[i]}, i);

    // reset during HOLD, then after 4 accepts
    async_reset("rst_hold");
    for (int i = 0; i < 4; i++) cycle(1, i + 1, 0, 0, "pre_rst");
    async_reset("rst_mid");

    // random traffic
    for (int n = 0; n < 600; n++)
      cycle(($urandom % 4) != 0, int'($urandom % 8), ($urandom % 12) == 0,
            ($urandom % 3) == 0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
